// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : stopwatch_pkg                                          |
// | Description : Shared state encoding, BCD digit limits and time-      |
// |               register helpers for the stopwatch controller.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package stopwatch_pkg;

  // 2'b11 is deliberately left unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  localparam logic [3:0] DIG_MAX   = 4'd9;
  localparam logic [3:0] SEC_T_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] cs_t;
    logic [3:0] cs_u;
  } time_t;

  // True when the display reads 59.99, the last representable value.
  function automatic logic time_is_max(input time_t t);
    return (t.sec_t == SEC_T_MAX) && (t.sec_u == DIG_MAX) &&
           (t.cs_t == DIG_MAX) && (t.cs_u == DIG_MAX);
  endfunction

  // One-centisecond BCD increment with ripple carry; saturates sec_t at 5.
  function automatic time_t bcd_inc(input time_t t);
    time_t r;
    r = t;
    if (t.cs_u != DIG_MAX) begin
      r.cs_u = t.cs_u + 4'd1;
    end else begin
      r.cs_u = 4'd0;
      if (t.cs_t != DIG_MAX) begin
        r.cs_t = t.cs_t + 4'd1;
      end else begin
        r.cs_t = 4'd0;
        if (t.sec_u != DIG_MAX) begin
          r.sec_u = t.sec_u + 4'd1;
        end else begin
          r.sec_u = 4'd0;
          if (t.sec_t != SEC_T_MAX) r.sec_t = t.sec_t + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_button_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : button_debounce                                        |
// | Description : Two-flop synchroniser, stability counter and one-cycle |
// |               press pulse for an active-low front-panel button.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module button_debounce #(
  parameter int DEB_N = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_n_i,
  output logic press_o
);

  // Counter spans 0..DEB_N-1; the DEB_N-th disagreeing sample commits.
  localparam int              CNT_W    = (DEB_N < 2) ? 1 : $clog2(DEB_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_N - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Accept a new level after DEB_N consecutive disagreeing samples; flag 1->0 only.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and debounce state; reset presets everything to "released".
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : stopwatch_ctrl                                         |
// | Description : Run/pause/clear FSM, centisecond prescaler and SS.CC   |
// |               BCD time register for the stopwatch display path.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10000,
  parameter int DEB_N    = 4
) (
  input  logic       CP,
  input  logic       invCR,
  input  logic       invSS,
  input  logic       invCLR,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [3:0] cs_t,
  output logic [3:0] cs_u,
  output logic       running,
  output logic       ovf
);

  import stopwatch_pkg::*;

  localparam int              PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_e           state_q;
  state_e           state_d;
  logic [PRE_W-1:0] presc_q;
  logic [PRE_W-1:0] presc_d;
  time_t            time_q;
  time_t            time_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             running_q;
  logic             ss_press;
  logic             clr_press;
  logic             tick;
  logic             at_max;

  button_debounce #(.DEB_N(DEB_N)) u_deb_ss (
    .clk_i   (CP),
    .rst_n_i (invCR),
    .btn_n_i (invSS),
    .press_o (ss_press)
  );

  button_debounce #(.DEB_N(DEB_N)) u_deb_clr (
    .clk_i   (CP),
    .rst_n_i (invCR),
    .btn_n_i (invCLR),
    .press_o (clr_press)
  );

  assign tick   = (state_q == ST_RUN) && (presc_q == PRE_LAST);
  assign at_max = time_is_max(time_q);

  // Next state, prescaler, time and overflow; anything landing in IDLE is cleared.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (ss_press) state_d = ST_RUN;
      end
      ST_RUN: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (at_max) ovf_d  = 1'b1;
          else        time_d = bcd_inc(time_q);
        end
        if (ss_press || (tick && at_max)) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clr_press)               state_d = ST_IDLE;
        else if (ss_press && !ovf_q) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      presc_d = '0;
      time_d  = '0;
      ovf_d   = 1'b0;
    end
  end

  // Controller registers; running is registered alongside the state.
  always_ff @(posedge CP) begin
    if (!invCR) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      time_q    <= '0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      time_q    <= time_d;
      ovf_q     <= ovf_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign sec_t   = time_q.sec_t;
  assign sec_u   = time_q.sec_u;
  assign cs_t    = time_q.cs_t;
  assign cs_u    = time_q.cs_u;
  assign running = running_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_stopwatch_ctrl                                      |
// | Description : Self-checking bench for stopwatch_ctrl: directed       |
// |               scenarios plus randomized button/reset traffic against |
// |               a behavioural centisecond-count model.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int DN = 2;

  logic       CP = 1'b0;
  logic       invCR = 1'b0;
  logic       invSS = 1'b1;
  logic       invCLR = 1'b1;
  logic [3:0] sec_t;
  logic [3:0] sec_u;
  logic [3:0] cs_t;
  logic [3:0] cs_u;
  logic       running;
  logic       ovf;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  stopwatch_ctrl #(.TICK_DIV(TD), .DEB_N(DN)) dut (
    .CP      (CP),
    .invCR   (invCR),
    .invSS   (invSS),
    .invCLR  (invCLR),
    .sec_t   (sec_t),
    .sec_u   (sec_u),
    .cs_t    (cs_t),
    .cs_u    (cs_u),
    .running (running),
    .ovf     (ovf)
  );

  always #5 CP = ~CP;

  // ---------------- behavioural model ----------------
  // Time kept as a plain centisecond count 0..5999; mode 0=idle 1=run 2=pause.
  int       m_t;
  bit       m_ovf;
  int       m_mode;
  int       m_ph;
  bit       m_run;
  bit [7:0] m_hist  [2];
  int       m_streak[2];
  bit       m_lvl   [2];
  bit       m_press [2];
  bit       m_ssp, m_clp, m_tick, m_hit, m_raw, m_s;

  always @(posedge CP) begin
    if (!invCR) begin
      m_t = 0; m_ovf = 0; m_mode = 0; m_ph = 0; m_run = 0;
      for (int b = 0; b < 2; b++) begin
        m_hist[b] = 8'hFF; m_streak[b] = 0; m_lvl[b] = 1; m_press[b] = 0;
      end
    end else begin
      m_ssp  = m_press[0];
      m_clp  = m_press[1];
      m_tick = (m_mode == 1) && (m_ph == TD - 1);
      m_hit  = 0;
      if (m_mode == 0) begin
        if (m_ssp) m_mode = 1;
      end else if (m_mode == 1) begin
        m_ph = m_tick ? 0 : m_ph + 1;
        if (m_tick) begin
          if (m_t == 5999) begin m_ovf = 1; m_hit = 1; end
          else m_t = m_t + 1;
        end
        if (m_ssp || m_hit) m_mode = 2;
      end else begin
        if (m_clp) begin m_mode = 0; m_t = 0; m_ph = 0; m_ovf = 0; end
        else if (m_ssp && !m_ovf) m_mode = 1;
      end
      m_run = (m_mode == 1);
      // Button seen two edges late; needs DN consecutive differing samples.
      for (int b = 0; b < 2; b++) begin
        m_raw = (b == 0) ? invSS : invCLR;
        m_s = m_hist[b][1];
        m_hist[b] = {m_hist[b][6:0], m_raw};
        m_press[b] = 0;
        if (m_s == m_lvl[b]) m_streak[b] = 0;
        else begin
          m_streak[b] = m_streak[b] + 1;
          if (m_streak[b] == DN) begin
            m_lvl[b] = m_s; m_streak[b] = 0; m_press[b] = !m_s;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [17:0] exp_v, got_v;
  always @(negedge CP) begin
    if (chk_en) begin
      exp_v = {4'(m_t / 1000), 4'((m_t / 100) % 10), 4'((m_t / 10) % 10),
               4'(m_t % 10), m_run, m_ovf};
      got_v = {sec_t, sec_u, cs_t, cs_u, running, ovf};
      vecs++;
      if (got_v !== exp_v) begin
        errs++;
        if (errs < 30)
          $display("FAIL model_cycle @%0t: got %h expected %h", $time, got_v, exp_v);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge CP);
    #2;
  endtask

  task automatic chk_time(input string nm, input int t, input bit r, input bit o);
    @(negedge CP);
    #1;
    chk({nm, "_time"}, {sec_t, sec_u, cs_t, cs_u},
        {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)});
    chk({nm, "_running"}, running, r);
    chk({nm, "_ovf"}, ovf, o);
  endtask

  task automatic push_ss(input int hold, input int after);
    invSS = 1'b0; tick_n(hold); invSS = 1'b1; tick_n(after);
  endtask

  task automatic push_clr(input int hold, input int after);
    invCLR = 1'b0; tick_n(hold); invCLR = 1'b1; tick_n(after);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with both buttons held down; then start from the held SS.
    invCR = 1'b0; invSS = 1'b0; invCLR = 1'b0;
    tick_n(1);
    chk_en = 1'b1;
    tick_n(2);
    chk_time("reset", 0, 0, 0);
    invCR = 1'b1;
    tick_n(4);
    @(negedge CP); #1; chk("start_edge4_running", running, 0);
    tick_n(1);
    @(negedge CP); #1; chk("start_edge5_running", running, 1);
    invSS = 1'b1; invCLR = 1'b1;
    tick_n(40);
    chk_time("ten_ticks", 10, 1, 0);

    // Pause, clear back to IDLE, then a bouncing SS that must not register.
    push_ss(4, 4);
    push_clr(4, 6);
    chk_time("clear_idle", 0, 0, 0);
    invSS = 1'b0; tick_n(1); invSS = 1'b1; tick_n(1);
    invSS = 1'b0; tick_n(1); invSS = 1'b1; tick_n(10);
    chk_time("bounce", 0, 0, 0);

    // Start, pause with prescaler at 2, hold, resume: next tick 2 cycles later.
    invSS = 1'b0; tick_n(4); invSS = 1'b1; tick_n(1);
    @(negedge CP); #1; chk("resume_start_running", running, 1);
    tick_n(37);
    invSS = 1'b0; tick_n(4); invSS = 1'b1; tick_n(1);
    chk_time("paused", 10, 0, 0);
    tick_n(50);
    chk_time("frozen", 10, 0, 0);
    invSS = 1'b0; tick_n(4); invSS = 1'b1; tick_n(1);
    chk_time("resumed", 10, 1, 0);
    tick_n(1);
    chk_time("resume_plus1", 10, 1, 0);
    tick_n(1);
    chk_time("resume_plus2", 11, 1, 0);

    // Overflow: run on until the FSM drops out of RUN at 59.99.
    begin : ovf_wait
      bit seen;
      seen = 0;
      for (int n = 0; n < 30000; n++) begin
        tick_n(1);
        if (running === 1'b0) begin seen = 1; break; end
      end
      chk("ovf_reached", seen, 1);
    end
    chk_time("overflow", 5999, 0, 1);
    push_ss(4, 6);
    chk_time("ovf_ss_ignored", 5999, 0, 1);
    push_clr(4, 6);
    chk_time("ovf_cleared", 0, 0, 0);

    // Priority: CLR ignored in RUN; simultaneous presses in PAUSE clear.
    push_ss(4, 2);
    push_clr(4, 4);
    @(negedge CP); #1; chk("clr_in_run_running", running, 1);
    push_ss(4, 4);
    @(negedge CP); #1; chk("paused_again_running", running, 0);
    invSS = 1'b0; invCLR = 1'b0; tick_n(4);
    invSS = 1'b1; invCLR = 1'b1; tick_n(3);
    chk_time("both_in_pause", 0, 0, 0);

    // Randomized button and reset traffic, checked by the model every cycle.
    repeat (400) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        invCR = 1'b0; tick_n($urandom_range(1, 3)); invCR = 1'b1;
      end else begin
        invSS  = 1'($urandom_range(0, 1));
        invCLR = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        tick_n($urandom_range(1, 8));
      end
    end
    invSS = 1'b1; invCLR = 1'b1;
    tick_n(10);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
